cla_adder_pipe: RTL and testbench

- Parametrised, pipelined successor to the 2-bit carry look-ahead adder.
- Splits a WIDTH-bit add into BLOCK-bit look-ahead groups, one group per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on input and output, so it drops into streaming datapaths at full throughput of one add per cycle.

---
 rtl/cla_adder_pipe.sv | 173 +++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry look-ahead adder with a valid/ready handshake.
//
// A WIDTH-bit add is split into BLOCK-bit look-ahead groups, one group per
// pipeline stage. The carry is registered between stages. The upper operand
// bits travel with the pipeline, and the completed low sum bits do too, so all
// bits of one result leave together. Operands are registered on acceptance.
// Latency is STAGES advance cycles after the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   a, b      operands (WIDTH)
//   cin       carry in
//   in_valid  operand valid
//   in_ready  adder accepts an operand this cycle (combinational)
//   sum       a+b+cin mod 2^WIDTH (registered)
//   cout      carry out of the MSB (registered)
//   out_valid sum/cout valid (registered)
//   out_ready downstream accepts the result
//   ovf       signed overflow, present only when CLA_ADDER_OVF_EN is defined
//
// Build option: define CLA_ADDER_OVF_EN to add the ovf output.

module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef CLA_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = WIDTH / BLOCK;
    localparam logic [WIDTH-1:0] GRP_MASK = WIDTH'({BLOCK{1'b1}});

    // One BLOCK-bit look-ahead group: returns {group carry out, sum bits}.
    // Every internal carry is a flat sum of products, so there is no ripple.
    function automatic logic [BLOCK:0] cla_group(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             ci
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] c;
        logic             term;
        logic             gg;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i + 1 < BLOCK; i++) begin
            term = ci;
            for (int unsigned j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        gg = 1'b0;
        for (int unsigned j = 0; j < BLOCK; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m < BLOCK; m++) begin
                term = term & p[m];
            end
            gg = gg | term;
        end
        pp = &p;
        return {gg | (pp & ci), p ^ c};
    endfunction

    // Stage registers: index 0 is the operand capture, index k+1 the output
    // of look-ahead stage k; index STAGES drives the outputs.
    logic             v_q [0:STAGES];
    logic             c_q [0:STAGES];
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];
    logic [WIDTH-1:0] s_q [1:STAGES];

    logic [WIDTH-1:0] s_nx [0:STAGES-1];
    logic             c_nx [0:STAGES-1];
    logic             adv;

    // Whole pipeline moves when the output slot is empty or being drained.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Per-stage look-ahead: group k from the skewed operands and the stage carry.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [BLOCK:0] grp;
        assign grp     = cla_group(a_q[k][k*BLOCK +: BLOCK], b_q[k][k*BLOCK +: BLOCK], c_q[k]);
        assign c_nx[k] = grp[BLOCK];
        if (k == 0) begin : g_first
            assign s_nx[k] = WIDTH'(grp[BLOCK-1:0]);
        end else begin : g_rest
            assign s_nx[k] = (s_q[k] & ~(GRP_MASK << (k*BLOCK)))
                           | (WIDTH'(grp[BLOCK-1:0]) << (k*BLOCK));
        end
    end

    // Pipeline registers; full stall when adv is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int unsigned k = 1; k <= STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            c_q[0] <= cin;
            a_q[0] <= a;
            b_q[0] <= b;
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= c_nx[k];
                s_q[k+1] <= s_nx[k];
            end
        end
    end

    assign sum       = s_q[STAGES];
    assign cout      = c_q[STAGES];
    assign out_valid = v_q[STAGES];

`ifdef CLA_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit; registered with the last stage.
    logic ovf_q;
    logic ovf_nx;
    assign ovf_nx = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                  ^ s_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_nx;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=16, BLOCK=4, latency 4).
module tb_cla_adder_pipe;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready;
`ifdef CLA_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CLA_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t         e;
        logic [W:0]   full;
        full   = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    // Scoreboard: push on accept, pop on consume; reset flushes everything.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
`ifdef CLA_ADDER_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, cin));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
        check("drain_empty", 32'(sb.size()), 32'(0));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Carry chain and exact latency
        send(16'hFFFF, 16'h0001, 1'b0);
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("lat_valid", 32'(out_valid), 32'(i == 4));
            if (i == 4) begin
                check("carry_sum", 32'(sum), 32'h0000);
                check("carry_cout", 32'(cout), 32'(1));
            end
        end
        drain();

        // Back-to-back streaming
        send(16'h1234, 16'h1111, 1'b0); cyc();
        send(16'h8000, 16'h8000, 1'b1); cyc();
        send(16'h00FF, 16'h0F01, 1'b0); cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("stream0_sum", 32'(sum), 32'h2345);
        check("stream0_cout", 32'(cout), 32'(0));
        cyc();
        check("stream1_sum", 32'(sum), 32'h0001);
        check("stream1_cout", 32'(cout), 32'(1));
        cyc();
        check("stream2_sum", 32'(sum), 32'h1000);
        check("stream2_cout", 32'(cout), 32'(0));
        drain();

        // Backpressure on a full pipeline
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            cyc();
        end
        send(16'hABCD, 16'h1357, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_in_ready", 32'(in_ready), 32'(0));
            check("stall_out_valid", 32'(out_valid), 32'(1));
            if (sb.size() != 0) begin
                check("stall_sum", 32'(sum), 32'(sb[0].sum));
                check("stall_cout", 32'(cout), 32'(sb[0].cout));
            end else begin
                check("stall_sb_nonempty", 32'(0), 32'(1));
            end
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();

        // Bubbles: in_valid 1,0,1
        send(16'h0102, 16'h0304, 1'b0); cyc();
        in_valid = 1'b0; cyc();
        send(16'hF00F, 16'h0FF1, 1'b1); cyc();
        in_valid = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            cyc();
            check("bubble_valid", 32'(out_valid), 32'(k == 4 || k == 6));
        end
        drain();

        // Reset with two operations in flight
        send(16'h1111, 16'h2222, 1'b0); cyc();
        send(16'h3333, 16'h4444, 1'b1); cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_cout", 32'(cout), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        send(16'h0003, 16'h0004, 1'b0); cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("post_rst_valid", 32'(out_valid), 32'(i == 4));
            if (i == 4) check("post_rst_sum", 32'(sum), 32'h0007);
        end
        drain();

`ifdef CLA_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0); cyc();
        send(16'h8000, 16'h8000, 1'b0); cyc();
        in_valid = 1'b0;
        drain();
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) send(W'($urandom), W'($urandom), 1'($urandom));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
